rr_arbiter_nbit: RTL

//   Round-robin arbiter sharing one resource among 2**N requesters.
//   - Grants one requester at a time and holds the grant until the owner releases it.
//   - Drives both an encoded grant index and a one-hot grant vector.
//   - The one-hot vector equals decoder_nbit(a=grant_idx, enable=grant_valid), so it can

---
 rtl/rr_arbiter_nbit.sv | 115 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_nbit.sv
// rr_arbiter_nbit
//   Round-robin arbiter sharing one resource among 2**N requesters. A grant
//   is held until the owner releases it, either with a done pulse or by
//   dropping its own request. Each release costs one idle cycle. The next
//   arbitration then starts one index past the previous owner.
//
// Parameters
//   N            index width; number of requesters = 2**N
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req          request vector, bit i belongs to requester i
//   done         owner release strobe (ignored while idle)
//   grant        one-hot grant, all zero when idle
//   grant_idx    index of the current owner, 0 when idle
//   grant_valid  a grant is active
module rr_arbiter_nbit #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2**N-1:0]   req,
    input  logic              done,
    output logic [2**N-1:0]   grant,
    output logic [N-1:0]      grant_idx,
    output logic              grant_valid
);

    localparam int NREQ = 2**N;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q,      state_d;
    logic [N-1:0]      ptr_q,        ptr_d;
    logic [N-1:0]      grantIdx_q,   grantIdx_d;
    logic [NREQ-1:0]   grant_q,      grant_d;
    logic              grantValid_q, grantValid_d;

    // Rotating priority search. The candidate index wraps naturally because
    // it is N bits wide. The first set request at or after ptr wins.
    logic [N-1:0]      winner;
    logic              found;
    logic [N-1:0]      cand;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr_q + N'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state logic. By default every register holds its value.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grantIdx_d   = grantIdx_q;
        grant_d      = grant_q;
        grantValid_d = grantValid_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = BUSY;
                    grantIdx_d   = winner;
                    grant_d      = NREQ'(1) << winner;
                    grantValid_d = 1'b1;
                end
            end
            BUSY: begin
                // The owner dropping its request counts as an implicit done.
                if (done || !req[grantIdx_q]) begin
                    state_d      = IDLE;
                    ptr_d        = grantIdx_q + N'(1);
                    grantIdx_d   = '0;
                    grant_d      = '0;
                    grantValid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grantIdx_q   <= '0;
            grant_q      <= '0;
            grantValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grantIdx_q   <= grantIdx_d;
            grant_q      <= grant_d;
            grantValid_q <= grantValid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grantIdx_q;
    assign grant_valid = grantValid_q;

endmodule
